// File: rtl/melody_pkg.sv
// Shared constants for the buzzer melody player: note codes, tone half-periods, FSM states, melody ROM.
package melody_pkg;

  localparam int unsigned MELODY_MAX = 21;
  localparam int unsigned HP_W       = 17;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NOTE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Note codes
  localparam logic [3:0] N_SIL    = 4'd0;
  localparam logic [3:0] N_DO     = 4'd1;
  localparam logic [3:0] N_DOS    = 4'd2;
  localparam logic [3:0] N_RE     = 4'd3;
  localparam logic [3:0] N_RES    = 4'd4;
  localparam logic [3:0] N_MI     = 4'd5;
  localparam logic [3:0] N_FAS    = 4'd6;
  localparam logic [3:0] N_SOL    = 4'd7;
  localparam logic [3:0] N_LA     = 4'd8;
  localparam logic [3:0] N_LAS    = 4'd9;
  localparam logic [3:0] N_SI     = 4'd10;
  localparam logic [3:0] N_DO_HI  = 4'd11;
  localparam logic [3:0] N_RES_HI = 4'd12;
  localparam logic [3:0] N_MI_HI  = 4'd13;

  // Half-periods in 50 MHz cycles, equal temperament around LA = 440 Hz
  localparam logic [HP_W-1:0] NOTE_HP [16] = '{
    17'd0,     17'd95556, 17'd90193, 17'd85131,
    17'd80353, 17'd75843, 17'd67569, 17'd63776,
    17'd56818, 17'd53629, 17'd50619, 17'd47778,
    17'd40177, 17'd37922, 17'd0,     17'd0
  };

  // End-of-cook tune: {code, duration in units}; step 1 is a one-unit rest
  function automatic logic [7:0] melody_rom(input logic [4:0] idx);
    logic [7:0] e;
    case (idx)
      5'd0:    e = {N_LA,     4'd3};
      5'd1:    e = {N_SIL,    4'd0};
      5'd2:    e = {N_MI_HI,  4'd2};
      5'd3:    e = {N_DO_HI,  4'd2};
      5'd4:    e = {N_LA,     4'd2};
      5'd5:    e = {N_SOL,    4'd2};
      5'd6:    e = {N_FAS,    4'd2};
      5'd7:    e = {N_MI,     4'd4};
      5'd8:    e = {N_SOL,    4'd2};
      5'd9:    e = {N_LA,     4'd2};
      5'd10:   e = {N_SI,     4'd2};
      5'd11:   e = {N_DO_HI,  4'd4};
      5'd12:   e = {N_RES_HI, 4'd2};
      5'd13:   e = {N_LAS,    4'd2};
      5'd14:   e = {N_RE,     4'd2};
      5'd15:   e = {N_RES,    4'd2};
      5'd16:   e = {N_DO,     4'd2};
      5'd17:   e = {N_DOS,    4'd2};
      5'd18:   e = {N_MI,     4'd2};
      5'd19:   e = {N_MI_HI,  4'd2};
      5'd20:   e = {N_LA,     4'd6};
      default: e = {N_SIL,    4'd1};
    endcase
    return e;
  endfunction

  function automatic logic [3:0] rom_code(input logic [4:0] idx);
    logic [7:0] e;
    e = melody_rom(idx);
    return e[7:4];
  endfunction

  function automatic logic [3:0] rom_dur(input logic [4:0] idx);
    logic [7:0] e;
    e = melody_rom(idx);
    return e[3:0];
  endfunction

endpackage

// File: rtl/melody_sequencer_tone_divider.sv
// Square-wave generator: toggles tone every half_period cycles while enabled, cleared otherwise.
module tone_divider #(
  parameter int unsigned DIV_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  output logic             tone
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tone;

  // Divider count and tone toggle; disable holds both cleared
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (r_cnt >= half_period - DIV_W'(1)) begin
      r_cnt  <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
    end
  end

  assign tone = r_tone;

endmodule

// File: rtl/melody_sequencer.sv
// Buzzer melody player: walks the melody ROM note by note with optional gaps, one-shot or looping.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter  int unsigned NUM_STEPS   = 21,
  parameter  int unsigned UNIT_CYCLES = 2500000,
  parameter  int unsigned GAP_UNITS   = 1,
  parameter  int unsigned HP_SHIFT    = 0,
  parameter  int unsigned DIV_W       = 17,
  localparam int unsigned SW          = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] step_idx,
  output logic [3:0]    note_code,
  output logic          tone
);

  localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned CW = 16;

  logic [1:0]       r_state, w_nxt_state;
  logic [SW-1:0]    r_step, w_nxt_step;
  logic [UW-1:0]    r_unit_cnt, w_nxt_unit;
  logic [CW-1:0]    r_dur_cnt, w_nxt_dur;
  logic             r_loop, w_nxt_loop;
  logic             w_nxt_done, w_enter;
  logic             r_busy, r_done;
  logic [3:0]       r_note;
  logic [3:0]       w_cur_code, w_cur_dur;
  logic [CW-1:0]    w_units;
  logic             w_unit_tick, w_phase_end, w_last;
  logic             w_div_en, w_tone;
  logic [DIV_W-1:0] w_hp_trunc, w_half_period;

  assign w_cur_code  = rom_code(5'(r_step));
  assign w_cur_dur   = rom_dur(5'(r_step));
  assign w_units     = (r_state == ST_NOTE) ?
                       ((w_cur_dur == 4'd0) ? CW'(1) : CW'(w_cur_dur)) : CW'(GAP_UNITS);
  assign w_unit_tick = (r_unit_cnt == UW'(UNIT_CYCLES - 1));
  assign w_phase_end = w_unit_tick && (r_dur_cnt == w_units - CW'(1));
  assign w_last      = (r_step == SW'(NUM_STEPS - 1));

  // Next-state, step and timing counters; stop beats start, start beats sequencing
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_step  = r_step;
    w_nxt_loop  = r_loop;
    w_nxt_done  = 1'b0;
    w_enter     = 1'b0;
    w_nxt_unit  = w_unit_tick ? '0 : r_unit_cnt + UW'(1);
    w_nxt_dur   = w_unit_tick ? r_dur_cnt + CW'(1) : r_dur_cnt;
    case (r_state)
      ST_NOTE, ST_GAP: begin
        if (w_phase_end) begin
          w_nxt_unit = '0;
          w_nxt_dur  = '0;
          if (r_state == ST_NOTE && GAP_UNITS > 0) begin
            w_nxt_state = ST_GAP;
          end else if (!w_last) begin
            w_nxt_state = ST_NOTE;
            w_nxt_step  = r_step + SW'(1);
            w_enter     = 1'b1;
          end else if (r_loop) begin
            w_nxt_state = ST_NOTE;
            w_nxt_step  = '0;
            w_enter     = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_step  = '0;
            w_nxt_done  = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_step  = '0;
        w_nxt_unit  = '0;
        w_nxt_dur   = '0;
      end
    endcase
    if (stop) begin
      w_nxt_state = ST_IDLE;
      w_nxt_step  = '0;
      w_nxt_unit  = '0;
      w_nxt_dur   = '0;
      w_nxt_done  = 1'b0;
      w_enter     = 1'b0;
    end else if (start) begin
      w_nxt_state = ST_NOTE;
      w_nxt_step  = '0;
      w_nxt_loop  = loop;
      w_nxt_unit  = '0;
      w_nxt_dur   = '0;
      w_nxt_done  = 1'b0;
      w_enter     = 1'b1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_step     <= '0;
      r_unit_cnt <= '0;
      r_dur_cnt  <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_step     <= w_nxt_step;
      r_unit_cnt <= w_nxt_unit;
      r_dur_cnt  <= w_nxt_dur;
      r_loop     <= w_nxt_loop;
    end
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_note <= '0;
    end else begin
      r_busy <= (w_nxt_state != ST_IDLE);
      r_done <= w_nxt_done;
      r_note <= (w_nxt_state == ST_NOTE) ? rom_code(5'(w_nxt_step)) : 4'd0;
    end
  end

  // Divider runs only while staying in a sounding note, so each note starts cleared and low
  assign w_div_en      = (w_nxt_state == ST_NOTE) && !w_enter && (w_cur_code != N_SIL);
  assign w_hp_trunc    = DIV_W'(NOTE_HP[w_cur_code] >> HP_SHIFT);
  assign w_half_period = (w_hp_trunc == '0) ? DIV_W'(1) : w_hp_trunc;

  tone_divider #(.DIV_W(DIV_W)) u_tone_divider (
    .clk         (clk),
    .rst         (rst),
    .en          (w_div_en),
    .half_period (w_half_period),
    .tone        (w_tone)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign step_idx  = r_step;
  assign note_code = r_note;
  assign tone      = w_tone;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: short-unit instance for sequencing, long-unit instance for tone timing.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst, start, stop, loop, l_start;

  logic       m_busy, m_done, m_tone;
  logic [1:0] m_step;
  logic [3:0] m_note;
  logic       l_busy, l_done, l_tone;
  logic [1:0] l_step;
  logic [3:0] l_note;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .NUM_STEPS(3), .UNIT_CYCLES(4), .GAP_UNITS(1), .HP_SHIFT(10), .DIV_W(17)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .busy(m_busy), .done(m_done), .step_idx(m_step), .note_code(m_note), .tone(m_tone)
  );

  melody_sequencer #(
    .NUM_STEPS(3), .UNIT_CYCLES(40), .GAP_UNITS(1), .HP_SHIFT(10), .DIV_W(17)
  ) u_long (
    .clk(clk), .rst(rst), .start(l_start), .stop(stop), .loop(loop),
    .busy(l_busy), .done(l_done), .step_idx(l_step), .note_code(l_note), .tone(l_tone)
  );

  wire [8:0] w_main = {m_busy, m_done, m_step, m_note, m_tone};
  wire [8:0] w_long = {l_busy, l_done, l_step, l_note, l_tone};

  function automatic logic [8:0] pk(input int b, input int d, input int s, input int n, input int t);
    return {1'(b), 1'(d), 2'(s), 4'(n), 1'(t)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {busy,done,step,note,tone}=%09b expected %09b", tag, obs, exp);
    end
  endtask

  // Cycles 1..36 of the 3-step melody: LA x3 units, rest (dur 0 -> 1 unit), MI_HI x2, gaps of 1 unit
  task automatic melody_body(input string tag);
    for (int i = 0; i < 12; i++) begin chk({tag, "_s0_note"}, w_main, pk(1, 0, 0, 8, 0));  tick; end
    for (int i = 0; i < 4; i++)  begin chk({tag, "_s0_gap"},  w_main, pk(1, 0, 0, 0, 0));  tick; end
    for (int i = 0; i < 4; i++)  begin chk({tag, "_s1_rest"}, w_main, pk(1, 0, 1, 0, 0));  tick; end
    for (int i = 0; i < 4; i++)  begin chk({tag, "_s1_gap"},  w_main, pk(1, 0, 1, 0, 0));  tick; end
    for (int i = 0; i < 8; i++)  begin chk({tag, "_s2_note"}, w_main, pk(1, 0, 2, 13, 0)); tick; end
    for (int i = 0; i < 4; i++)  begin chk({tag, "_s2_gap"},  w_main, pk(1, 0, 2, 0, 0));  tick; end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; l_start = 1'b0;
    tick; tick;
    chk("reset_main", w_main, pk(0, 0, 0, 0, 0));
    chk("reset_long", w_long, pk(0, 0, 0, 0, 0));
    rst = 1'b0;
    tick;

    // Tone timing on LA (half period 55): low for cycles 1..55, high from 56
    l_start = 1'b1; tick; l_start = 1'b0;
    chk("long_c1", w_long, pk(1, 0, 0, 8, 0));
    for (int c = 2; c <= 60; c++) begin
      tick;
      if (c == 55) chk("long_c55", w_long, pk(1, 0, 0, 8, 0));
      if (c == 56) chk("long_c56", w_long, pk(1, 0, 0, 8, 1));
      if (c == 60) chk("long_c60", w_long, pk(1, 0, 0, 8, 1));
    end
    // Restart while tone is high: tone drops and the divider restarts from zero
    l_start = 1'b1; tick; l_start = 1'b0;
    chk("long_restart_c1", w_long, pk(1, 0, 0, 8, 0));
    for (int c = 2; c <= 56; c++) begin
      tick;
      if (c == 55) chk("long_restart_c55", w_long, pk(1, 0, 0, 8, 0));
      if (c == 56) chk("long_restart_c56", w_long, pk(1, 0, 0, 8, 1));
    end
    stop = 1'b1; tick; stop = 1'b0;
    chk("long_stop", w_long, pk(0, 0, 0, 0, 0));
    chk("main_idle_pre", w_main, pk(0, 0, 0, 0, 0));

    // One-shot melody
    loop = 1'b0; start = 1'b1; tick; start = 1'b0;
    melody_body("oneshot");
    chk("oneshot_done", w_main, pk(0, 1, 0, 0, 0));
    tick;
    chk("oneshot_idle", w_main, pk(0, 0, 0, 0, 0));
    tick;

    // Looping melody; loop dropped after start to show it is latched
    loop = 1'b1; start = 1'b1; tick; start = 1'b0; loop = 1'b0;
    melody_body("loop");
    chk("loop_wrap", w_main, pk(1, 0, 0, 8, 0));
    tick;
    chk("loop_wrap2", w_main, pk(1, 0, 0, 8, 0));
    stop = 1'b1; tick; stop = 1'b0;
    chk("loop_stop", w_main, pk(0, 0, 0, 0, 0));
    tick;
    chk("loop_stop_hold", w_main, pk(0, 0, 0, 0, 0));

    // Reset mid-note, then replay
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("pre_rst", w_main, pk(1, 0, 0, 8, 0));
    rst = 1'b1; tick; rst = 1'b0;
    chk("rst_mid", w_main, pk(0, 0, 0, 0, 0));
    start = 1'b1; tick; start = 1'b0;
    chk("replay", w_main, pk(1, 0, 0, 8, 0));

    // Restart from step 1
    for (int i = 0; i < 17; i++) tick;
    chk("mid_s1", w_main, pk(1, 0, 1, 0, 0));
    start = 1'b1; tick; start = 1'b0;
    chk("restart", w_main, pk(1, 0, 0, 8, 0));
    tick;
    chk("restart_c2", w_main, pk(1, 0, 0, 8, 0));

    // start and stop together: stop wins, busy and idle
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    chk("ss_busy", w_main, pk(0, 0, 0, 0, 0));
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    chk("ss_idle", w_main, pk(0, 0, 0, 0, 0));
    tick;
    chk("ss_idle2", w_main, pk(0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
